// File: rtl/ps2_key_decoder_pkg.sv
// Shared types for the camera key path: the keys_t event bundle, set-2 scan codes
// and the decoder state encoding.
package ps2_key_decoder_pkg;

  typedef struct packed {
    logic [1:0] w;
    logic [1:0] a;
    logic [1:0] s;
    logic [1:0] d;
    logic [1:0] q;
    logic [1:0] e;
    logic       pressed;
    logic       released;
  } keys_t;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} dec_state_t;

  // One-hot key select in held order {e,q,d,s,a,w}; zero for unmapped codes.
  function automatic logic [5:0] key_hit(input logic [7:0] code);
    logic [5:0] hit;
    hit = '0;
    case (code)
      SC_W: hit = 6'b000001;
      SC_A: hit = 6'b000010;
      SC_S: hit = 6'b000100;
      SC_D: hit = 6'b001000;
      SC_Q: hit = 6'b010000;
      SC_E: hit = 6'b100000;
      default: hit = '0;
    endcase
    return hit;
  endfunction

  function automatic keys_t key_event(input logic [5:0] hit, input logic rel);
    keys_t k;
    k          = '0;
    k.w        = {rel & hit[0], ~rel & hit[0]};
    k.a        = {rel & hit[1], ~rel & hit[1]};
    k.s        = {rel & hit[2], ~rel & hit[2]};
    k.d        = {rel & hit[3], ~rel & hit[3]};
    k.q        = {rel & hit[4], ~rel & hit[4]};
    k.e        = {rel & hit[5], ~rel & hit[5]};
    k.pressed  = ~rel & (|hit);
    k.released = rel & (|hit);
    return k;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the keyboard wires and the decoded key outputs of ps2_key_decoder.
interface ps2_key_decoder_if;
  import ps2_key_decoder_pkg::*;

  logic       ps2_clk;
  logic       ps2_data;
  keys_t      keys;
  logic [5:0] held;
  logic       frame_err;

  modport master (input ps2_clk, input ps2_data, output keys, output held, output frame_err);
  modport slave  (output ps2_clk, output ps2_data, input keys, input held, input frame_err);
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 byte receiver: synchronises the keyboard lines, shifts in 11-bit frames and
// flags framing, parity and mid-frame timeout errors.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall_p0, din_p0, frame_ok_p0;
  logic [3:0]             bit_cnt;
  logic [TW-1:0]          to_cnt;
  logic [9:0]             shreg;

  assign fall_p0     = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign din_p0      = data_sync[SYNC_STAGES-1];
  // shreg[0] is the start bit, [8:1] data, [9] parity; din_p0 is the stop bit.
  assign frame_ok_p0 = ~shreg[0] & din_p0 & (^shreg[9:1]);

  // Stage p0: synchronise and detect the falling edge of the keyboard clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  // Stage p1: frame bookkeeping, byte strobe and error pulses.
  always_ff @(posedge clk) begin
    byte_valid <= 1'b0;
    frame_err  <= 1'b0;
    if (rst) begin
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else if (fall_p0) begin
      to_cnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt    <= '0;
        byte_valid <= frame_ok_p0;
        frame_err  <= ~frame_ok_p0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (bit_cnt != 4'd0) begin
      if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
        bit_cnt   <= '0;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fall_p0) begin
      shreg <= {din_p0, shreg[9:1]};
      if (bit_cnt == 4'd10) rx_byte <= shreg[8:1];
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Camera key front end: turns PS/2 make/break sequences into one-shot keys_t
// pulses with typematic repeats and extended-prefix codes filtered out.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic           clk,
  input  logic           rst,
  ps2_key_decoder_if.master bus
);
  logic [7:0] byte_p1;
  logic       vld_p1, err_p1;
  logic [5:0] hit_p1;
  dec_state_t state;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .rx_byte   (byte_p1),
    .byte_valid(vld_p1),
    .frame_err (err_p1)
  );

  assign hit_p1        = key_hit(byte_p1);
  assign bus.frame_err = err_p1;

  // Stage p2: decoder FSM, held register and the keys pulse register.
  always_ff @(posedge clk) begin
    bus.keys <= '0;
    if (rst) begin
      state    <= ST_IDLE;
      bus.held <= '0;
    end else if (err_p1) begin
      state <= ST_IDLE;
    end else if (vld_p1) begin
      case (state)
        ST_IDLE: begin
          if (byte_p1 == SC_BREAK) begin
            state <= ST_BRK;
          end else if (byte_p1 == SC_EXT) begin
            state <= ST_EXT;
          end else if ((hit_p1 != '0) && ((hit_p1 & bus.held) == '0)) begin
            bus.keys <= key_event(hit_p1, 1'b0);
            bus.held <= bus.held | hit_p1;
          end
        end
        ST_BRK: begin
          if ((hit_p1 & bus.held) != '0) begin
            bus.keys <= key_event(hit_p1, 1'b1);
            bus.held <= bus.held & ~hit_p1;
          end
          state <= ST_IDLE;
        end
        ST_EXT:     state <= (byte_p1 == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames, expected events queued
// by the stimulus and checked by an independent output monitor.
module tb_ps2_key_decoder;
  import ps2_key_decoder_pkg::*;

  localparam int TO = 200;

  typedef struct {
    keys_t      k;
    logic       err;
    logic [5:0] held;
    bit         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   stop_cyc = 0;
  exp_t exp_q[$];

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic keys_t kev(input int idx, input bit rel);
    keys_t k;
    k = '0;
    case (idx)
      0: k.w = rel ? 2'b10 : 2'b01;
      1: k.a = rel ? 2'b10 : 2'b01;
      2: k.s = rel ? 2'b10 : 2'b01;
      3: k.d = rel ? 2'b10 : 2'b01;
      4: k.q = rel ? 2'b10 : 2'b01;
      default: k.e = rel ? 2'b10 : 2'b01;
    endcase
    k.pressed  = !rel;
    k.released = rel;
    return k;
  endfunction

  task automatic expect_key(input int idx, input bit rel, input logic [5:0] held);
    exp_t e;
    e.k = kev(idx, rel); e.err = 1'b0; e.held = held; e.lat = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [5:0] held);
    exp_t e;
    e.k = '0; e.err = 1'b1; e.held = held; e.lat = 1'b0;
    exp_q.push_back(e);
  endtask

  // Drives nbits of a frame (start, data LSB first, odd parity, stop), 8 clk per bit.
  task automatic send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      repeat (4) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (4) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic sendb(input logic [7:0] b);
    send(b, 1'b0, 11);
  endtask

  // Monitor: every non-idle output cycle must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.keys != '0 || bus.frame_err)) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: keys=%h err=%b required no event", bus.keys, bus.frame_err);
        end else begin
          e = exp_q.pop_front();
          chk("keys", 32'(bus.keys), 32'(e.k));
          chk("frame_err", 32'(bus.frame_err), 32'(e.err));
          chk("held_at_event", 32'(bus.held), 32'(e.held));
          if (e.lat) chk("latency", 32'(cyc - stop_cyc), 32'd4);
        end
      end
    end
  end

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_keys", 32'(bus.keys), 32'd0);
    chk("reset_held", 32'(bus.held), 32'd0);
    chk("reset_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Break of a key never pressed: no pulse.
    sendb(8'hF0); sendb(8'h1D);
    chk("held_orphan_break", 32'(bus.held), 32'd0);

    // a press, typematic repeats, release.
    expect_key(1, 1'b0, 6'b000010);
    sendb(8'h1C);
    chk("held_a", 32'(bus.held), 32'h02);
    sendb(8'h1C); sendb(8'h1C);
    expect_key(1, 1'b1, 6'b000000);
    sendb(8'hF0); sendb(8'h1C);
    chk("held_a_rel", 32'(bus.held), 32'h00);

    // w press, d press, w release.
    expect_key(0, 1'b0, 6'b000001); sendb(8'h1D);
    expect_key(3, 1'b0, 6'b001001); sendb(8'h23);
    expect_key(0, 1'b1, 6'b001000); sendb(8'hF0); sendb(8'h1D);
    chk("held_wd", 32'(bus.held), 32'h08);

    // Extended make and break are swallowed; FSM back in IDLE afterwards.
    sendb(8'hE0); sendb(8'h75);
    sendb(8'hE0); sendb(8'hF0); sendb(8'h75);
    expect_key(0, 1'b0, 6'b001001); sendb(8'h1D);
    chk("held_after_ext", 32'(bus.held), 32'h09);

    // Parity error, then a truncated frame that times out, then a clean e.
    expect_err(6'b001001);
    send(8'h1C, 1'b1, 11);
    expect_err(6'b001001);
    send(8'h00, 1'b0, 6);
    repeat (TO + 20) @(negedge clk);
    expect_key(5, 1'b0, 6'b101001); sendb(8'h24);
    chk("held_e", 32'(bus.held), 32'h29);

    // Reset with a pending F0 and keys held: held cleared silently.
    sendb(8'hF0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_held", 32'(bus.held), 32'd0);
    chk("rst_keys", 32'(bus.keys), 32'd0);
    expect_key(0, 1'b0, 6'b000001); sendb(8'h1D);
    chk("held_after_rst", 32'(bus.held), 32'h01);

    repeat (20) @(negedge clk);
    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
